// File: rtl/assoc_table_pkg.sv
// Shared types for the associative key/value table: request opcodes,
// response status codes and controller states.
package assoc_table_pkg;

  localparam int OP_W     = 3;
  localparam int STATUS_W = 2;

  typedef enum logic [OP_W-1:0] {
    INSERT = 3'd0,
    LOOKUP = 3'd1,
    EXISTS = 3'd2,
    DELETE = 3'd3,
    CLEAR  = 3'd4
  } op_e;

  typedef enum logic [STATUS_W-1:0] {
    OK        = 2'd0,
    NOT_FOUND = 2'd1,
    FULL      = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CLR  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/assoc_table_store.sv
// Key/value/valid storage with one asynchronous indexed read port, one write
// port and a single-cycle clear of every valid flag.
module assoc_table_store #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 16,
  parameter int VAL_W = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic [VAL_W-1:0] rd_val,
  output logic             rd_vld,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_val,
  input  logic             wr_vld,
  input  logic             clr_all
);

  logic [KEY_W-1:0] key_mem [DEPTH];
  logic [VAL_W-1:0] val_mem [DEPTH];
  logic [DEPTH-1:0] vld_q;

  assign rd_key = key_mem[rd_idx];
  assign rd_val = val_mem[rd_idx];
  assign rd_vld = vld_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (clr_all) begin
      vld_q <= '0;
    end else if (wr_en) begin
      vld_q[wr_idx] <= wr_vld;
    end
  end

  // Key and value contents carry no reset; only the valid flags define liveness.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_idx] <= wr_key;
      val_mem[wr_idx] <= wr_val;
    end
  end

endmodule

// File: rtl/assoc_table_ctrl.sv
// Request sequencer for the associative table: linear scan FSM, lowest free
// slot tracking, live entry count and a held valid/ready response.
module assoc_table_ctrl
  import assoc_table_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KEY_W = 16,
  parameter int VAL_W = 32,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [KEY_W-1:0]    req_key,
  input  logic [VAL_W-1:0]    req_val,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [STATUS_W-1:0] resp_status,
  output logic [VAL_W-1:0]    resp_val,
  output logic [CNT_W-1:0]    num,
  output logic                full
);

  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= DEPTH_CNT) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [KEY_W-1:0]      key_q;
  logic [VAL_W-1:0]      val_q;
  logic                  free_found_q, free_found_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
  logic [CNT_W-1:0]      num_q, num_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [VAL_W-1:0]      rval_q, rval_d;

  logic [KEY_W-1:0]      rd_key;
  logic [VAL_W-1:0]      rd_val;
  logic                  rd_vld;
  logic                  wr_en, wr_vld, clr_all;
  logic [IDX_W-1:0]      wr_idx;
  logic                  accept, hit, op_known;

  assign req_ready   = rst_n && (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (state_q == RESP);
  assign resp_status = status_q;
  assign resp_val    = rval_q;
  assign num         = num_q;
  assign full        = (num_q == DEPTH_CNT);
  assign hit         = rd_vld && (rd_key == key_q);
  assign op_known    = (op_q <= 3'(DELETE));

  assoc_table_store #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W),
    .VAL_W (VAL_W),
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (idx_q),
    .rd_key  (rd_key),
    .rd_val  (rd_val),
    .rd_vld  (rd_vld),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_key  (key_q),
    .wr_val  (val_q),
    .wr_vld  (wr_vld),
    .clr_all (clr_all)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    num_d        = num_q;
    status_d     = status_q;
    rval_d       = rval_q;
    wr_en        = 1'b0;
    wr_idx       = idx_q;
    wr_vld       = 1'b1;
    clr_all      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = req_op;
          idx_d        = '0;
          free_found_d = 1'b0;
          free_idx_d   = '0;
          state_d      = (req_op == 3'(CLEAR)) ? CLR : SCAN;
        end
      end
      SCAN: begin
        idx_d = idx_q + 1'b1;
        if (!rd_vld && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (!op_known) begin
          status_d = NOT_FOUND;
          rval_d   = '0;
          state_d  = RESP;
        end else if (hit) begin
          status_d = OK;
          rval_d   = '0;
          state_d  = RESP;
          case (op_q)
            3'(INSERT): wr_en = 1'b1;
            3'(LOOKUP): rval_d = rd_val;
            3'(DELETE): begin
              wr_en  = 1'b1;
              wr_vld = 1'b0;
              num_d  = sat_dec(num_q);
            end
            default: ;
          endcase
        end else if (idx_q == LAST_IDX) begin
          // Final entry missed too; the free slot may be this very entry.
          rval_d  = '0;
          state_d = RESP;
          if (op_q == 3'(INSERT)) begin
            if (free_found_q || !rd_vld) begin
              wr_en    = 1'b1;
              wr_idx   = free_found_q ? free_idx_q : idx_q;
              num_d    = sat_inc(num_q);
              status_d = OK;
            end else begin
              status_d = FULL;
            end
          end else begin
            status_d = NOT_FOUND;
          end
        end
      end
      CLR: begin
        clr_all  = 1'b1;
        num_d    = '0;
        status_d = OK;
        rval_d   = '0;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      num_q        <= '0;
      status_q     <= OK;
      rval_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      num_q        <= num_d;
      status_q     <= status_d;
      rval_q       <= rval_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      key_q <= req_key;
      val_q <= req_val;
    end
  end

endmodule

// File: tb/tb_assoc_table_ctrl.sv
// Directed bench for assoc_table_ctrl at DEPTH=4: a vector table of
// operations with expected status/value/count/latency, plus corner sequences.
module tb_assoc_table_ctrl;
  import assoc_table_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_key;
  logic [7:0] req_val;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_status;
  logic [7:0] resp_val;
  logic [2:0] num;
  logic       full;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assoc_table_ctrl #(
    .DEPTH (4),
    .KEY_W (8),
    .VAL_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_key     (req_key),
    .req_val     (req_val),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .resp_val    (resp_val),
    .num         (num),
    .full        (full)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] key;
    logic [7:0] val;
    logic [1:0] st;
    logic [7:0] rv;
    int         cnt;
    int         lat;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and completes its response; lat is the cycle index
  // (request cycle = 0) on which resp_valid is first seen.
  task automatic do_op(input logic [2:0] op, input logic [7:0] k, input logic [7:0] v,
                       output logic [1:0] st, output logic [7:0] rv, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 40) begin
      tick();
      guard++;
    end
    chk("req_ready before request", int'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = k;
    req_val   = v;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    st = resp_status;
    rv = resp_val;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] st;
    logic [7:0] rv;
    logic [1:0] st_hold;
    logic [7:0] rv_hold;
    int         lat;
    int         guard;

    // Table starts empty; values are chosen as key*0x11 where convenient.
    vecs[0]  = '{INSERT, 8'h10, 8'hAA, OK,        8'h00, 1, 5};
    vecs[1]  = '{LOOKUP, 8'h10, 8'h00, OK,        8'hAA, 1, 2};
    vecs[2]  = '{LOOKUP, 8'h11, 8'h00, NOT_FOUND, 8'h00, 1, 5};
    vecs[3]  = '{INSERT, 8'h10, 8'hBB, OK,        8'h00, 1, 2};
    vecs[4]  = '{LOOKUP, 8'h10, 8'h00, OK,        8'hBB, 1, 2};
    vecs[5]  = '{DELETE, 8'h10, 8'h00, OK,        8'h00, 0, 2};
    vecs[6]  = '{EXISTS, 8'h10, 8'h00, NOT_FOUND, 8'h00, 0, 5};
    vecs[7]  = '{INSERT, 8'h01, 8'h11, OK,        8'h00, 1, 5};
    vecs[8]  = '{INSERT, 8'h02, 8'h22, OK,        8'h00, 2, 5};
    vecs[9]  = '{INSERT, 8'h03, 8'h33, OK,        8'h00, 3, 5};
    vecs[10] = '{INSERT, 8'h04, 8'h44, OK,        8'h00, 4, 5};
    vecs[11] = '{INSERT, 8'h05, 8'h55, FULL,      8'h00, 4, 5};
    vecs[12] = '{DELETE, 8'h02, 8'h00, OK,        8'h00, 3, 3};
    vecs[13] = '{INSERT, 8'h05, 8'h55, OK,        8'h00, 4, 5};
    vecs[14] = '{LOOKUP, 8'h05, 8'h00, OK,        8'h55, 4, 3};
    vecs[15] = '{EXISTS, 8'h04, 8'h00, OK,        8'h00, 4, 5};
    vecs[16] = '{LOOKUP, 8'h02, 8'h00, NOT_FOUND, 8'h00, 4, 5};
    vecs[17] = '{DELETE, 8'h04, 8'h00, OK,        8'h00, 3, 5};
    vecs[18] = '{CLEAR,  8'h00, 8'h00, OK,        8'h00, 0, 2};
    vecs[19] = '{LOOKUP, 8'h01, 8'h00, NOT_FOUND, 8'h00, 0, 5};
    vecs[20] = '{CLEAR,  8'h00, 8'h00, OK,        8'h00, 0, 2};
    vecs[21] = '{3'd7,   8'h01, 8'h00, NOT_FOUND, 8'h00, 0, 2};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_key    = 8'h00;
    req_val    = 8'h00;
    resp_ready = 1'b0;
    tick();
    tick();
    chk("reset req_ready",   int'(req_ready),   0);
    chk("reset resp_valid",  int'(resp_valid),  0);
    chk("reset num",         int'(num),         0);
    chk("reset full",        int'(full),        0);
    chk("reset resp_status", int'(resp_status), 0);
    chk("reset resp_val",    int'(resp_val),    0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) begin
      do_op(vecs[i].op, vecs[i].key, vecs[i].val, st, rv, lat);
      chk($sformatf("v%0d status", i),  int'(st),   int'(vecs[i].st));
      chk($sformatf("v%0d resp_val", i), int'(rv),  int'(vecs[i].rv));
      chk($sformatf("v%0d latency", i), lat,        vecs[i].lat);
      chk($sformatf("v%0d num", i),     int'(num),  vecs[i].cnt);
      chk($sformatf("v%0d full", i),    int'(full), (vecs[i].cnt == 4) ? 1 : 0);
    end

    // Response backpressure on a LOOKUP hit.
    do_op(INSERT, 8'h30, 8'h77, st, rv, lat);
    chk("bp insert status", int'(st), int'(OK));
    req_valid = 1'b1;
    req_op    = LOOKUP;
    req_key   = 8'h30;
    tick();
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk("bp resp_valid", int'(resp_valid), 1);
    st_hold = resp_status;
    rv_hold = resp_val;
    chk("bp status", int'(st_hold), int'(OK));
    chk("bp resp_val", int'(rv_hold), 8'h77);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp hold%0d valid", c),  int'(resp_valid),  1);
      chk($sformatf("bp hold%0d status", c), int'(resp_status), int'(st_hold));
      chk($sformatf("bp hold%0d val", c),    int'(resp_val),    int'(rv_hold));
      chk($sformatf("bp hold%0d ready", c),  int'(req_ready),   0);
    end
    resp_ready = 1'b1;
    chk("bp handshake req_ready", int'(req_ready), 0);
    tick();
    resp_ready = 1'b0;
    chk("bp after resp_valid", int'(resp_valid), 0);
    chk("bp after req_ready", int'(req_ready), 1);
    do_op(EXISTS, 8'h30, 8'h00, st, rv, lat);
    chk("bp next status", int'(st), int'(OK));
    chk("bp next latency", lat, 2);

    // Reset in the middle of an INSERT scan abandons it and empties the table.
    req_valid = 1'b1;
    req_op    = INSERT;
    req_key   = 8'h20;
    req_val   = 8'h99;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midscan resp_valid", int'(resp_valid), 0);
    chk("midscan num", int'(num), 0);
    chk("midscan req_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    tick();
    do_op(EXISTS, 8'h20, 8'h00, st, rv, lat);
    chk("midscan exists 20", int'(st), int'(NOT_FOUND));
    do_op(EXISTS, 8'h30, 8'h00, st, rv, lat);
    chk("midscan exists 30", int'(st), int'(NOT_FOUND));
    chk("midscan final num", int'(num), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_table_ctrl.md
Name: assoc_table_ctrl

Overview:
Sequencing controller for a fixed-depth hardware key/value table with the semantics of a SystemVerilog associative array. It serves one requester through a valid/ready request/response pair. Supported operations are insert/overwrite, lookup, exists, single-key delete and delete-all. It tracks a live entry count equivalent to num()/size(). Entries are searched by a sequential scan FSM, one entry per cycle.

Parameters:
DEPTH, 8, number of table entries (>=2)
KEY_W, 16, key width in bits
VAL_W, 32, value width in bits
CNT_W, $clog2(DEPTH+1), width of the entry count

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request (IDLE only)
req_op  in  3  op_e: INSERT, LOOKUP, EXISTS, DELETE, CLEAR
req_key  in  KEY_W  key (ignored for CLEAR)
req_val  in  VAL_W  value (INSERT only)
resp_valid  out  1  response present
resp_ready  in  1  requester accepts response
resp_status  out  2  status_e: OK, NOT_FOUND, FULL
resp_val  out  VAL_W  value on LOOKUP hit, else 0
num  out  CNT_W  live entry count
full  out  1  num == DEPTH

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; all entry valid flags cleared.
  - num=0, full=0, resp_valid=0, resp_status=OK, resp_val=0, req_ready=0 during reset.
  - Reset mid-scan or mid-response abandons the operation; no table write.
- States:
  - IDLE: req_ready=1. Accept on req_valid&req_ready at cycle T. Latch op, key and value. CLEAR goes to CLR; all other ops go to SCAN with idx=0.
  - SCAN: compare entry[idx] (valid && key==req_key) once per cycle. Idx runs 0..DEPTH-1 across cycles T+1..T+DEPTH.
    - Hit at idx i: terminate and go to RESP. resp_valid rises at T+i+2.
    - INSERT also records the lowest-index free slot seen during the scan.
    - Miss after idx DEPTH-1: go to RESP. resp_valid rises at T+DEPTH+1.
  - CLR: clear all valid flags in one cycle, set num=0, go to RESP. resp_valid rises at T+2.
  - RESP: hold resp_valid, resp_status and resp_val stable until resp_ready is high. Return to IDLE on the handshake cycle; req_ready is 0 on that cycle.
- Operation results:
  - INSERT hit: overwrite the value, num unchanged, OK.
  - INSERT miss with a free slot: write key, value and valid into the lowest free slot, num+1, OK.
  - INSERT miss with no free slot: no write, FULL.
  - LOOKUP hit: OK with resp_val set to the stored value. Miss: NOT_FOUND with resp_val=0.
  - EXISTS: OK or NOT_FOUND, with resp_val=0.
  - DELETE hit: clear the valid flag, num-1, OK. Miss: NOT_FOUND, no change.
  - CLEAR: always OK, including when the table is already empty.
- Timing of table writes: writes and num updates are committed on the SCAN-exit cycle. They are visible to the next request.
- Ordering: one operation in flight; requests are processed strictly in order.
- Count bounds: num never exceeds DEPTH and never underflows. full is combinational from num.
- Keys: duplicate keys are never stored. Key 0 is a legal key.

Decomposition:
- Package assoc_table_pkg:
  - op_e enum (3 bits): INSERT=0, LOOKUP=1, EXISTS=2, DELETE=3, CLEAR=4. Other codes respond NOT_FOUND after one SCAN cycle is skipped, i.e. via RESP at T+2.
  - status_e enum (2 bits): OK=0, NOT_FOUND=1, FULL=2.
  - state_e enum: IDLE, SCAN, CLR, RESP.
- Sub-module assoc_table_store:
  - Holds the key, value and valid arrays.
  - One indexed read port and one write port.
  - Single-cycle valid-clear-all input.
  - Reset clears valid flags only.
- assoc_table_ctrl holds the FSM, scan index, free-slot tracker and count.

Test Plan:
(DEPTH=4, KEY_W=8, VAL_W=8 for all scenarios.)
1. Basic insert/lookup/miss:
   - Reset, then INSERT k=0x10 v=0xAA -> OK, num=1, resp at T+5 (miss path).
   - LOOKUP 0x10 -> OK, val=0xAA, resp at T+2.
   - LOOKUP 0x11 -> NOT_FOUND, val=0.
2. Overwrite and delete:
   - INSERT 0x10 v=0xBB on an existing key -> OK, num stays 1; LOOKUP returns 0xBB.
   - DELETE 0x10 -> OK, num=0.
   - EXISTS 0x10 -> NOT_FOUND.
3. Fill and overflow:
   - INSERT keys 1,2,3,4 -> OK each, num=4, full=1.
   - INSERT 5 -> FULL, num=4.
   - DELETE 2, then INSERT 5 -> 5 lands in slot 1; LOOKUP 5 hits at idx 1 with resp at T+3.
4. Clear:
   - With num=3, CLEAR -> OK at T+2, num=0.
   - LOOKUP of any prior key -> NOT_FOUND.
   - CLEAR on an empty table -> OK.
5. Response backpressure:
   - Hold resp_ready=0 for 5 cycles after a LOOKUP hit -> resp fields stable, req_ready=0 throughout.
   - Release resp_ready -> return to IDLE; the next request is accepted the following cycle.
6. Reset mid-scan:
   - Assert rst_n=0 during the SCAN of an INSERT with new key 0x20 -> resp_valid=0, num=0.
   - After reset, EXISTS 0x20 -> NOT_FOUND.
